dm_arbiter: RTL and testbench
=============================

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter: DEPTH_W, 10, word-address width of the data memory (1024 words).
REQ-002 Ports (N in {0,1}; port 0 = core load/store, port 1 = debug/DMA):
- clk  in  1  single clock; all state updates on its rising edge.
- rstn  in  1  asynchronous, active-low reset.
- pN_req  in  1  access request; held stable with all pN_* command inputs until pN_gnt.
- pN_we  in  1  1 = store, 0 = load.
- pN_addr  in  32  byte address; bits [1:0] ignored.
- pN_be  in  4  byte-lane write enables, already lane-aligned.
- pN_wdata  in  32  store data, already lane-aligned.
- pN_gnt  out  1  command accepted this cycle.
- pN_rvalid  out  1  one-cycle pulse; pN_rdata valid.
- pN_rdata  out  32  raw word read from memory.
- pN_err  out  1  one-cycle pulse with pN_gnt; address out of range.
- mem_en  out  1  memory access enable.
- mem_addr  out  DEPTH_W  word address = granted addr[DEPTH_W+1:2].
- mem_wea  out  4  byte write enables.
- mem_wdata  out  32  write data.
- mem_rdata  in  32  read data, valid one cycle after an mem_en read.

Function
REQ-003 The FSM SHALL have two states: IDLE and RD_WAIT.
REQ-004 In IDLE with at least one req, exactly one pN_gnt SHALL assert combinationally in that cycle, and the command SHALL drive mem_* in the same cycle.
REQ-005 Arbitration SHALL be round-robin: if both req, grant the port not in last_gnt; if one req, grant it.
REQ-006 last_gnt SHALL update to the granted port on every grant, including error grants.
REQ-007 A granted store SHALL drive mem_en=1, mem_wea=pN_be, mem_wdata=pN_wdata; FSM remains IDLE (1-cycle store).
REQ-008 A store with pN_be=0000 SHALL be granted with mem_en=1, mem_wea=0000 (no-op).
REQ-009 A granted load SHALL drive mem_en=1, mem_wea=0000, record owner, go to RD_WAIT.
REQ-010 In RD_WAIT: owner rvalid=1, owner rdata=mem_rdata, no gnt, mem_en=0; next state IDLE.
REQ-011 A load occupies 2 cycles; the next grant is issued no earlier than the cycle after rvalid.
REQ-012 pN_addr[31:DEPTH_W+2] nonzero SHALL grant with pN_err=1, mem_en=0, mem_wea=0000, FSM stays IDLE, no rvalid.
REQ-013 Non-owner rvalid SHALL be 0; rdata of a port without rvalid SHALL be 0.
REQ-014 When no grant: mem_en=0, mem_wea=0000, mem_addr/mem_wdata held at 0.
REQ-015 A req deasserted without gnt SHALL be dropped silently.

Reset
REQ-016 rstn low SHALL immediately force IDLE, last_gnt=1 (port 0 wins first tie), owner=0.
REQ-017 During and after reset all gnt, rvalid, err, mem_en SHALL be 0 and mem_wea=0000.
REQ-018 Reset in RD_WAIT SHALL abort the load; no rvalid SHALL follow.

Structure
REQ-019 Package dm_pkg SHALL hold the state enum (IDLE, RD_WAIT), port index constants PORT_CORE=0, PORT_DBG=1, and WEA_NONE=4'b0000.
REQ-020 Round-robin select SHALL be a sub-module dm_rr_arb (inputs req[1:0], last_gnt; output one-hot gnt).

Verification
REQ-021 Scenario: after reset, both req loads at 0x10 and 0x20 -> p0_gnt cycle 0, p0_rvalid cycle 1, p1_gnt cycle 2, p1_rvalid cycle 3, mem_addr 4 then 8.
REQ-022 Scenario: p0 store be=0100 wdata=0x00AB0000 addr 0x8 -> same-cycle gnt, mem_wea=0100, mem_addr=2, FSM stays IDLE; read back 0x00AB0000 on p1.
REQ-023 Scenario: p1 load addr 0x00001000 (DEPTH_W=10) -> p1_gnt=1, p1_err=1, mem_en=0, no rvalid.
REQ-024 Scenario: both req stores continuously for 6 cycles -> grants alternate 0,1,0,1,0,1.
REQ-025 Scenario: rstn low in RD_WAIT -> rvalid stays 0, state IDLE, next tie grants port 0.
REQ-026 Scenario: p0 store be=0000 -> p0_gnt=1, mem_en=1, mem_wea=0000, memory unchanged.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared types and constants for the two-port data-memory arbiter.
// Imported by dm_rr_arb and dm_arbiter.
package dm_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      RD_WAIT = 1'b1
   } dm_state_e;

   localparam logic       PORT_CORE = 1'b0;
   localparam logic       PORT_DBG  = 1'b1;
   localparam logic [3:0] WEA_NONE  = 4'b0000;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wdata;
   } dm_cmd_t;

   // True when any byte-address bit above the memory's word range is set.
   function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned depth_w);
      return (addr >> (depth_w + 2)) != 32'd0;
   endfunction

endpackage

// File: rtl/dm_rr_arb.sv
// Two-requester round-robin select: on a tie the port that did not win last
// time is granted. Output is one-hot (or zero when nobody requests).
module dm_rr_arb
   import dm_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last_gnt == PORT_CORE) ? 2'b10 : 2'b01;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// Arbitrates the core load/store port and the debug/DMA port onto a single
// synchronous data memory; stores take one cycle, loads two.
module dm_arbiter
   import dm_pkg::*;
#(
   parameter int DEPTH_W = 10
) (
   input  logic               clk,
   input  logic               rstn,

   input  logic               p0_req,
   input  logic               p0_we,
   input  logic [31:0]        p0_addr,
   input  logic [3:0]         p0_be,
   input  logic [31:0]        p0_wdata,
   output logic               p0_gnt,
   output logic               p0_rvalid,
   output logic [31:0]        p0_rdata,
   output logic               p0_err,

   input  logic               p1_req,
   input  logic               p1_we,
   input  logic [31:0]        p1_addr,
   input  logic [3:0]         p1_be,
   input  logic [31:0]        p1_wdata,
   output logic               p1_gnt,
   output logic               p1_rvalid,
   output logic [31:0]        p1_rdata,
   output logic               p1_err,

   output logic               mem_en,
   output logic [DEPTH_W-1:0] mem_addr,
   output logic [3:0]         mem_wea,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata
);

   dm_state_e state_q, state_d;
   logic      last_gnt_q, last_gnt_d;
   logic      owner_q, owner_d;

   logic [1:0] arb_req;
   logic [1:0] arb_gnt;
   dm_cmd_t    cmd0, cmd1, sel_cmd;
   logic       sel_port;
   logic       sel_err;

   assign cmd0 = '{we: p0_we, addr: p0_addr, be: p0_be, wdata: p0_wdata};
   assign cmd1 = '{we: p1_we, addr: p1_addr, be: p1_be, wdata: p1_wdata};

   // Requests are only visible to the arbiter while idle and out of reset, so
   // nothing is granted while rstn is held low or a load is completing.
   assign arb_req = (state_q == IDLE && rstn) ? {p1_req, p0_req} : 2'b00;

   dm_rr_arb u_rr_arb (
      .req      (arb_req),
      .last_gnt (last_gnt_q),
      .gnt      (arb_gnt)
   );

   assign sel_port = arb_gnt[1];
   assign sel_cmd  = sel_port ? cmd1 : cmd0;
   assign sel_err  = addr_out_of_range(sel_cmd.addr, DEPTH_W);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         last_gnt_q <= PORT_DBG;
         owner_q    <= PORT_CORE;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
      end
   end

   // Next-state and all outputs; mem_* stay at zero except on a good grant.
   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      p0_gnt     = 1'b0;
      p1_gnt     = 1'b0;
      p0_err     = 1'b0;
      p1_err     = 1'b0;
      p0_rvalid  = 1'b0;
      p1_rvalid  = 1'b0;
      p0_rdata   = 32'd0;
      p1_rdata   = 32'd0;
      mem_en     = 1'b0;
      mem_addr   = '0;
      mem_wea    = WEA_NONE;
      mem_wdata  = 32'd0;

      case (state_q)
         IDLE: begin
            if (arb_gnt != 2'b00) begin
               p0_gnt     = arb_gnt[0];
               p1_gnt     = arb_gnt[1];
               last_gnt_d = sel_port;
               if (sel_err) begin
                  p0_err = arb_gnt[0];
                  p1_err = arb_gnt[1];
               end else begin
                  mem_en   = 1'b1;
                  mem_addr = DEPTH_W'(sel_cmd.addr >> 2);
                  if (sel_cmd.we) begin
                     mem_wea   = sel_cmd.be;
                     mem_wdata = sel_cmd.wdata;
                  end else begin
                     owner_d = sel_port;
                     state_d = RD_WAIT;
                  end
               end
            end
         end

         RD_WAIT: begin
            if (owner_q == PORT_CORE) begin
               p0_rvalid = 1'b1;
               p0_rdata  = mem_rdata;
            end else begin
               p1_rvalid = 1'b1;
               p1_rdata  = mem_rdata;
            end
            state_d = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a 1024-word byte-lane memory model
// answering mem_* one cycle after each enabled access.
module tb_dm_arbiter;

   localparam int DEPTH_W = 10;

   logic               clk = 1'b0;
   logic               rstn;
   logic               p0_req, p0_we, p1_req, p1_we;
   logic [31:0]        p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [3:0]         p0_be, p1_be;
   logic               p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
   logic [31:0]        p0_rdata, p1_rdata;
   logic               mem_en;
   logic [DEPTH_W-1:0] mem_addr;
   logic [3:0]         mem_wea;
   logic [31:0]        mem_wdata;
   logic [31:0]        mem_rdata;

   logic [31:0]        mem_model [0:1023];
   int                 checks = 0;
   int                 errors = 0;

   always #5 clk = ~clk;

   dm_arbiter #(.DEPTH_W(DEPTH_W)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .p0_req    (p0_req),
      .p0_we     (p0_we),
      .p0_addr   (p0_addr),
      .p0_be     (p0_be),
      .p0_wdata  (p0_wdata),
      .p0_gnt    (p0_gnt),
      .p0_rvalid (p0_rvalid),
      .p0_rdata  (p0_rdata),
      .p0_err    (p0_err),
      .p1_req    (p1_req),
      .p1_we     (p1_we),
      .p1_addr   (p1_addr),
      .p1_be     (p1_be),
      .p1_wdata  (p1_wdata),
      .p1_gnt    (p1_gnt),
      .p1_rvalid (p1_rvalid),
      .p1_rdata  (p1_rdata),
      .p1_err    (p1_err),
      .mem_en    (mem_en),
      .mem_addr  (mem_addr),
      .mem_wea   (mem_wea),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata)
   );

   // Memory preloaded with 0xA500_0000|index, word 2 cleared; read-first.
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < 1024; i++) mem_model[i] <= 32'hA500_0000 | 32'(i);
         mem_model[2] <= 32'd0;
         mem_rdata    <= 32'd0;
      end else if (mem_en) begin
         for (int b = 0; b < 4; b++)
            if (mem_wea[b]) mem_model[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
         mem_rdata <= mem_model[mem_addr];
      end
   end

   task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   task automatic apply_p0(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
      p0_req = req; p0_we = we; p0_addr = addr; p0_be = be; p0_wdata = wdata;
   endtask

   task automatic apply_p1(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wdata);
      p1_req = req; p1_we = we; p1_addr = addr; p1_be = be; p1_wdata = wdata;
   endtask

   initial begin
      rstn = 1'b0;
      apply_p0(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
      apply_p1(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);

      // Requests during reset must not be granted
      @(negedge clk);
      apply_p0(1'b1, 1'b0, 32'h10, 4'hF, 32'd0);
      apply_p1(1'b1, 1'b0, 32'h20, 4'hF, 32'd0);
      #1;
      check_output("rst_p0_gnt", 32'(p0_gnt), 32'd0);
      check_output("rst_p1_gnt", 32'(p1_gnt), 32'd0);
      check_output("rst_mem_en", 32'(mem_en), 32'd0);
      check_output("rst_mem_wea", 32'(mem_wea), 32'd0);
      check_output("rst_rvalid", 32'({p1_rvalid, p0_rvalid}), 32'd0);

      // Tied loads: p0 first, then p1 after its rvalid
      @(negedge clk);
      rstn = 1'b1;
      #1;
      check_output("ld_c0_p0_gnt", 32'(p0_gnt), 32'd1);
      check_output("ld_c0_p1_gnt", 32'(p1_gnt), 32'd0);
      check_output("ld_c0_mem_en", 32'(mem_en), 32'd1);
      check_output("ld_c0_mem_addr", 32'(mem_addr), 32'd4);
      check_output("ld_c0_mem_wea", 32'(mem_wea), 32'd0);
      @(negedge clk);
      p0_req = 1'b0;
      #1;
      check_output("ld_c1_p0_rvalid", 32'(p0_rvalid), 32'd1);
      check_output("ld_c1_p0_rdata", p0_rdata, 32'hA500_0004);
      check_output("ld_c1_p1_gnt", 32'(p1_gnt), 32'd0);
      check_output("ld_c1_mem_en", 32'(mem_en), 32'd0);
      check_output("ld_c1_p1_rvalid", 32'(p1_rvalid), 32'd0);
      check_output("ld_c1_p1_rdata", p1_rdata, 32'd0);
      @(negedge clk);
      #1;
      check_output("ld_c2_p1_gnt", 32'(p1_gnt), 32'd1);
      check_output("ld_c2_mem_addr", 32'(mem_addr), 32'd8);
      check_output("ld_c2_p0_rvalid", 32'(p0_rvalid), 32'd0);
      @(negedge clk);
      p1_req = 1'b0;
      #1;
      check_output("ld_c3_p1_rvalid", 32'(p1_rvalid), 32'd1);
      check_output("ld_c3_p1_rdata", p1_rdata, 32'hA500_0008);
      check_output("ld_c3_p0_rdata", p0_rdata, 32'd0);

      // Single-lane store on p0, read back on p1 the next cycle
      @(negedge clk);
      apply_p0(1'b1, 1'b1, 32'h8, 4'b0100, 32'h00AB_0000);
      #1;
      check_output("st_p0_gnt", 32'(p0_gnt), 32'd1);
      check_output("st_mem_en", 32'(mem_en), 32'd1);
      check_output("st_mem_wea", 32'(mem_wea), 32'b0100);
      check_output("st_mem_addr", 32'(mem_addr), 32'd2);
      check_output("st_mem_wdata", mem_wdata, 32'h00AB_0000);
      @(negedge clk);
      p0_req = 1'b0;
      apply_p1(1'b1, 1'b0, 32'h8, 4'd0, 32'd0);
      #1;
      check_output("st_next_p1_gnt", 32'(p1_gnt), 32'd1);
      check_output("st_no_p0_rvalid", 32'(p0_rvalid), 32'd0);
      @(negedge clk);
      p1_req = 1'b0;
      #1;
      check_output("st_readback", p1_rdata, 32'h00AB_0000);

      // Out-of-range load on p1
      @(negedge clk);
      apply_p1(1'b1, 1'b0, 32'h0000_1000, 4'd0, 32'd0);
      #1;
      check_output("err_p1_gnt", 32'(p1_gnt), 32'd1);
      check_output("err_p1_err", 32'(p1_err), 32'd1);
      check_output("err_p0_err", 32'(p0_err), 32'd0);
      check_output("err_mem_en", 32'(mem_en), 32'd0);
      check_output("err_mem_wea", 32'(mem_wea), 32'd0);
      @(negedge clk);
      p1_req = 1'b0;
      #1;
      check_output("err_no_rvalid", 32'(p1_rvalid), 32'd0);
      check_output("idle_mem_en", 32'(mem_en), 32'd0);
      check_output("idle_mem_addr", 32'(mem_addr), 32'd0);
      check_output("idle_mem_wdata", mem_wdata, 32'd0);

      // Zero-byte-enable store is a granted no-op
      @(negedge clk);
      apply_p0(1'b1, 1'b1, 32'h10, 4'b0000, 32'hFFFF_FFFF);
      #1;
      check_output("be0_p0_gnt", 32'(p0_gnt), 32'd1);
      check_output("be0_mem_en", 32'(mem_en), 32'd1);
      check_output("be0_mem_wea", 32'(mem_wea), 32'd0);
      @(negedge clk);
      p0_req = 1'b0;
      apply_p1(1'b1, 1'b0, 32'h10, 4'd0, 32'd0);
      #1;
      check_output("be0_rd_gnt", 32'(p1_gnt), 32'd1);
      @(negedge clk);
      p1_req = 1'b0;
      #1;
      check_output("be0_unchanged", p1_rdata, 32'hA500_0004);

      // Continuous tied stores alternate starting with p0 (last grant was p1)
      @(negedge clk);
      apply_p0(1'b1, 1'b1, 32'h40, 4'hF, 32'h1111_1111);
      apply_p1(1'b1, 1'b1, 32'h44, 4'hF, 32'h2222_2222);
      for (int i = 0; i < 6; i++) begin
         #1;
         check_output($sformatf("rr%0d_p0_gnt", i), 32'(p0_gnt), (i % 2 == 0) ? 32'd1 : 32'd0);
         check_output($sformatf("rr%0d_p1_gnt", i), 32'(p1_gnt), (i % 2 == 0) ? 32'd0 : 32'd1);
         check_output($sformatf("rr%0d_mem_addr", i), 32'(mem_addr), (i % 2 == 0) ? 32'd16 : 32'd17);
         @(negedge clk);
      end

      // Reset while p0 load is in RD_WAIT; the next tie must go to p0 again
      p1_req = 1'b0;
      apply_p0(1'b1, 1'b0, 32'h10, 4'd0, 32'd0);
      #1;
      check_output("rstrd_p0_gnt", 32'(p0_gnt), 32'd1);
      @(negedge clk);
      p0_req = 1'b0;
      rstn   = 1'b0;
      #1;
      check_output("rstrd_p0_rvalid", 32'(p0_rvalid), 32'd0);
      check_output("rstrd_p0_rdata", p0_rdata, 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      apply_p0(1'b1, 1'b0, 32'h20, 4'd0, 32'd0);
      apply_p1(1'b1, 1'b0, 32'h20, 4'd0, 32'd0);
      #1;
      check_output("rstrd_tie_p0_gnt", 32'(p0_gnt), 32'd1);
      check_output("rstrd_tie_p1_gnt", 32'(p1_gnt), 32'd0);
      check_output("rstrd_no_rvalid", 32'(p0_rvalid), 32'd0);
      @(negedge clk);
      p0_req = 1'b0;
      p1_req = 1'b0;
      #1;
      check_output("rstrd_tie_rdata", p0_rdata, 32'hA500_0008);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
